// File: rtl/axi_mem_loader.sv
// axi_mem_loader: AXI4-Lite write-only slave that turns host writes into single-cycle memory word writes.
// Define AXI_MEM_LOADER_STRB_CHECK_EN to reject partial-strobe writes with SLVERR.
module axi_mem_loader #(
  parameter int          MEM_AW    = 9,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic              axi_mem_w,
  output logic [MEM_AW-1:0] axi_mem_addr,
  output logic [31:0]       axi_mem_data,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
  state_t state_q, state_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, off;
  logic [3:0] wstrb_q, wstrb_d;
  logic aw_acc, w_acc, go, ok;
  logic awready_q, wready_q, bvalid_q, mem_w_q, busy_q;
  logic [1:0] bresp_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0] mem_data_q;
  always_comb begin
    aw_acc = s_awvalid && awready_q;
    w_acc = s_wvalid && wready_q;
    awaddr_d = aw_acc ? s_awaddr : awaddr_q;
    wdata_d = w_acc ? s_wdata : wdata_q;
    wstrb_d = w_acc ? s_wstrb : wstrb_q;
    go = (state_q == IDLE) && (aw_held_q || aw_acc) && (w_held_q || w_acc);
    aw_held_d = (state_q == WRITE) ? 1'b0 : aw_held_q || aw_acc;
    w_held_d = (state_q == WRITE) ? 1'b0 : w_held_q || w_acc;
    off = awaddr_d - BASE_ADDR;
`ifdef AXI_MEM_LOADER_STRB_CHECK_EN
    ok = (off[1:0] == 2'b00) && (off[31:MEM_AW+2] == '0) && (wstrb_d == 4'hF);
`else
    ok = (off[1:0] == 2'b00) && (off[31:MEM_AW+2] == '0);
`endif
    state_d = go ? WRITE :
              (state_q == WRITE) ? RESP :
              (state_q == RESP && s_bready) ? IDLE : state_q;
  end
  // Readies, bvalid and busy are derived from next state so every output stays registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      mem_w_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      awready_q  <= (state_d == IDLE) && !aw_held_d;
      wready_q   <= (state_d == IDLE) && !w_held_d;
      bvalid_q   <= state_d == RESP;
      bresp_q    <= go ? (ok ? 2'b00 : 2'b10) : bresp_q;
      mem_w_q    <= go && ok;
      mem_addr_q <= (go && ok) ? off[MEM_AW+1:2] : mem_addr_q;
      mem_data_q <= (go && ok) ? wdata_d : mem_data_q;
      busy_q     <= (state_d != IDLE) || aw_held_d || w_held_d;
    end
  end
`ifndef AXI_MEM_LOADER_STRB_CHECK_EN
  logic unused_strb;
  assign unused_strb = ^wstrb_q;
`endif
  assign s_awready    = awready_q;
  assign s_wready     = wready_q;
  assign s_bvalid     = bvalid_q;
  assign s_bresp      = bresp_q;
  assign axi_mem_w    = mem_w_q;
  assign axi_mem_addr = mem_addr_q;
  assign axi_mem_data = mem_data_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_axi_mem_loader.sv
// tb_axi_mem_loader: directed self-checking bench for axi_mem_loader.
module tb_axi_mem_loader;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] s_awaddr = '0, s_wdata = '0;
  logic [3:0] s_wstrb = '0;
  logic s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
  logic s_awready, s_wready, s_bvalid, axi_mem_w, busy;
  logic [1:0] s_bresp;
  logic [8:0] axi_mem_addr;
  logic [31:0] axi_mem_data;
  int tests = 0, fails = 0, wr_cnt = 0, b_cnt = 0;
  logic [8:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0] resp;
  int w0;

  axi_mem_loader #(.MEM_AW(9), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .axi_mem_w(axi_mem_w), .axi_mem_addr(axi_mem_addr), .axi_mem_data(axi_mem_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (axi_mem_w) begin
      wr_cnt++;
      wr_addr = axi_mem_addr;
      wr_data = axi_mem_data;
    end
    if (s_bvalid && s_bready) b_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic aw_beat(input logic [31:0] a);
    s_awaddr = a;
    s_awvalid = 1'b1;
    for (int n = 0; n < 50 && !s_awready; n++) tick;
    chk("aw_ready", s_awready, 1);
    tick;
    s_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s);
    s_wdata = d;
    s_wstrb = s;
    s_wvalid = 1'b1;
    for (int n = 0; n < 50 && !s_wready; n++) tick;
    chk("w_ready", s_wready, 1);
    tick;
    s_wvalid = 1'b0;
  endtask

  task automatic both_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    s_awaddr = a;
    s_wdata = d;
    s_wstrb = s;
    s_awvalid = 1'b1;
    s_wvalid = 1'b1;
    for (int n = 0; n < 50 && !(s_awready && s_wready); n++) tick;
    chk("both_ready", {s_awready, s_wready}, 2'b11);
    tick;
    s_awvalid = 1'b0;
    s_wvalid = 1'b0;
  endtask

  task automatic wait_b(output logic [1:0] r);
    for (int n = 0; n < 50 && !s_bvalid; n++) tick;
    chk("bvalid", s_bvalid, 1);
    r = s_bresp;
    s_bready = 1'b1;
    tick;
  endtask

  initial begin
    s_bready = 1'b1;
    tick;
    tick;
    chk("rst_vals", {s_awready, s_wready, s_bvalid, s_bresp, axi_mem_w, axi_mem_addr, axi_mem_data, busy}, 64'h0);
    reset = 1'b0;
    tick;
    chk("rst_rise", {s_awready, s_wready, busy}, 3'b110);

    both_beat(32'h10, 32'hDEAD_BEEF, 4'hF);
    chk("t1_w", {axi_mem_w, axi_mem_addr, axi_mem_data}, {1'b1, 9'h004, 32'hDEAD_BEEF});
    chk("t1_rdy", {s_awready, s_wready, s_bvalid, busy}, 4'b0001);
    tick;
    chk("t1_b", {axi_mem_w, s_bvalid, s_bresp}, 4'b0100);
    tick;
    chk("t1_idle", {s_bvalid, s_awready, s_wready, busy}, 4'b0110);
    chk("t1_cnt", {wr_cnt[7:0], b_cnt[7:0]}, 16'h0101);

    w_beat(32'h1234_5678, 4'hF);
    chk("t2_hold", {s_wready, s_awready, busy}, 3'b011);
    tick;
    tick;
    chk("t2_nowr", axi_mem_w, 0);
    aw_beat(32'h7FC);
    chk("t2_w", {axi_mem_w, axi_mem_addr, axi_mem_data}, {1'b1, 9'h1FF, 32'h1234_5678});
    wait_b(resp);
    chk("t2_resp", resp, 2'b00);

    w0 = wr_cnt;
    both_beat(32'h800, 32'h1111_1111, 4'hF);
    wait_b(resp);
    chk("t3_range", resp, 2'b10);
    both_beat(32'h6, 32'h2222_2222, 4'hF);
    wait_b(resp);
    chk("t3_align", resp, 2'b10);
    chk("t3_nowr", wr_cnt - w0, 0);

    w0 = wr_cnt;
    both_beat(32'h0, 32'h3333_4444, 4'h3);
    wait_b(resp);
`ifdef AXI_MEM_LOADER_STRB_CHECK_EN
    chk("t4_resp", resp, 2'b10);
    chk("t4_cnt", wr_cnt - w0, 0);
`else
    chk("t4_resp", resp, 2'b00);
    chk("t4_wr", {wr_cnt - w0, wr_addr, wr_data}, {32'd1, 9'h000, 32'h3333_4444});
`endif

    s_bready = 1'b0;
    both_beat(32'h20, 32'hAAAA_5555, 4'hF);
    tick;
    s_awaddr = 32'h24;
    s_awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t5_stall", {s_bvalid, s_bresp, s_awready, s_wready}, 5'b10000);
      tick;
    end
    s_bready = 1'b1;
    tick;
    chk("t5_rel", {s_bvalid, s_awready, s_wready}, 3'b011);
    tick;
    s_awvalid = 1'b0;
    chk("t5_acc", {s_awready, s_wready, busy}, 3'b011);
    w_beat(32'h5A5A_A5A5, 4'hF);
    chk("t5_w", {axi_mem_w, axi_mem_addr, axi_mem_data}, {1'b1, 9'h009, 32'h5A5A_A5A5});
    wait_b(resp);
    chk("t5_resp", resp, 2'b00);

    w0 = wr_cnt;
    b_cnt = 0;
    aw_beat(32'h30);
    reset = 1'b1;
    tick;
    chk("t6_rst", {s_awready, s_wready, s_bvalid, s_bresp, axi_mem_w, axi_mem_addr, axi_mem_data, busy}, 64'h0);
    reset = 1'b0;
    tick;
    chk("t6_drop", {wr_cnt - w0, b_cnt}, 64'h0);
    both_beat(32'h40, 32'hCAFE_F00D, 4'hF);
    chk("t6_w", {axi_mem_w, axi_mem_addr, axi_mem_data}, {1'b1, 9'h010, 32'hCAFE_F00D});
    wait_b(resp);
    chk("t6_resp", resp, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
